// File: rtl/muxn_pkg.sv
// muxn_pkg: shared constants, scan state type and select-width helper
// for the muxn_scan registered multiplexer.
package muxn_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_scan_ctr.sv
// muxn_scan_ctr: auto-scan dwell counter and channel counter with wrap.
// clr has priority over en so a manual edge always parks the scan at 0.
module muxn_scan_ctr
    import muxn_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int SCAN_DIV = 4,
    localparam int SW       = sel_w(N_CH),
    localparam int DCW      = sel_w(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [SW-1:0] ch
);

    localparam logic [DCW-1:0] DW_LAST = DCW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]  CH_LAST = SW'(N_CH - 1);

    logic [DCW-1:0] dwell;

    // Dwell counts enabled scan cycles; channel advances when dwell wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
            ch    <= '0;
        end else if (clr) begin
            dwell <= '0;
            ch    <= '0;
        end else if (en) begin
            if (dwell == DW_LAST) begin
                dwell <= '0;
                ch    <= (ch == CH_LAST) ? '0 : ch + SW'(1);
            end else begin
                dwell <= dwell + DCW'(1);
            end
        end
    end

endmodule

// File: rtl/muxn_scan.sv
// muxn_scan: N-channel registered mux with range guard and auto-scan.
// Optional even-parity output y_par under `MUXN_SCAN_PARITY_EN.
module muxn_scan
    import muxn_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int DW       = 8,
    parameter  int SCAN_DIV = 4,
    localparam int SW       = sel_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N_CH*DW-1:0] d,
    input  logic [SW-1:0]    s,
    output logic [DW-1:0]    y,
    output logic [SW-1:0]    y_ch,
`ifdef MUXN_SCAN_PARITY_EN
    output logic             y_par,
`endif
    output logic             y_vld
);

    state_t         state_q;
    state_t         state_d;
    logic [SW-1:0]  sel;
    logic [SW-1:0]  scan_ch;
    logic           ctr_en;
    logic           ctr_clr;
    logic           in_rng;
    logic [DW-1:0]  y_d;

    muxn_scan_ctr #(
        .N_CH     (N_CH),
        .SCAN_DIV (SCAN_DIV)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctr_en),
        .clr   (ctr_clr),
        .ch    (scan_ch)
    );

    // Mode state register follows mode on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MANUAL;
        else        state_q <= state_d;
    end

    // Next state and select; the entry edge into scan forces channel 0.
    always_comb begin
        state_d = state_q;
        sel     = s;
        ctr_en  = 1'b0;
        ctr_clr = 1'b0;
        if (en) state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
        if (mode == MODE_SCAN) begin
            sel    = (state_q == SCAN) ? scan_ch : '0;
            ctr_en = en;
        end else begin
            ctr_clr = en;
        end
    end

    // Range check and data select; out-of-range selects yield zero.
    always_comb begin
        in_rng = 32'(sel) < 32'(N_CH);
        y_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SW'(i)) y_d = d[i*DW +: DW];
        end
    end

    // Output registers load only on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            y_ch  <= '0;
            y_vld <= 1'b0;
        end else if (en) begin
            y     <= y_d;
            y_ch  <= sel;
            y_vld <= in_rng;
        end
    end

`ifdef MUXN_SCAN_PARITY_EN
    // Parity register tracks the value loaded into y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  y_par <= 1'b0;
        else if (en) y_par <= ^y_d;
    end
`endif

endmodule

// File: doc/muxn_scan.md
# muxn_scan

Parametrised N-channel, W-bit registered multiplexer that generalises the 4:1 single-bit mux. It adds a registered output, an out-of-range select guard, and an auto-scan mode that steps through the channels with a programmable dwell time. It sits between the channel data sources and downstream display or capture logic, and also serves as the bench target for the next mux assignment.

## Interface
Parameters:
- N_CH, default 4: number of input channels; legal range 2..16.
- DW, default 8: data width per channel.
- SCAN_DIV, default 4: dwell per channel in auto-scan, counted in enabled cycles; must be ≥1.
- SW, derived as max(1, $clog2(N_CH)): select width. Not user-overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  advance/sample enable.
- mode  in  1  0 = manual select, 1 = auto-scan.
- d  in  N_CH*DW  packed channel data; channel i occupies d[i*DW +: DW].
- s  in  SW  manual channel select.
- y  out  DW  registered selected data.
- y_ch  out  SW  channel index that produced y.
- y_vld  out  1  y holds valid channel data.
- y_par  out  1  even parity of y. Present only with MUXN_SCAN_PARITY_EN.

## Operation
- The block has one clock, and reset is asynchronous and active-low. On rst_n=0, all of the following take effect immediately:
  - y = 0, y_ch = 0, y_vld = 0, y_par = 0.
  - Scan channel = 0, dwell counter = 0.
- Channel selection on each rising edge with en=1:
  - Manual (mode=0): sel = s.
  - Auto (mode=1): sel = scan channel.
  - Outputs load y = d[sel], y_ch = sel, y_vld = 1.
- Out-of-range select: if sel ≥ N_CH (only possible when N_CH is not a power of 2), load y = 0, y_ch = sel, y_vld = 0.
- en=0: y, y_ch, y_vld, the scan channel and the dwell counter all hold.
- Auto-scan counters, evaluated on each enabled edge in auto mode:
  - If dwell = SCAN_DIV−1: dwell → 0 and scan channel → (scan channel + 1), wrapping from N_CH−1 to 0.
  - Otherwise: dwell increments.
  - Each channel therefore appears on y for exactly SCAN_DIV enabled cycles.
- Mode transitions:
  - Manual→auto: at the first edge where mode=1 is sampled with en=1, sel = 0. The scan channel and dwell restart from 0, so the scan always begins at channel 0 with a full dwell.
  - Auto→manual: the next enabled edge uses s. The scan state is cleared to 0.
- Reset asserted mid-scan forces the reset state immediately. The first enabled edge after release samples channel 0 in auto mode, or s in manual mode.

## Timing
- Latency is 1 cycle: d, s, mode and en sampled at edge k determine y, y_ch and y_vld after edge k.
- There is no combinational path from any input to any output.
- d may change every cycle. Only the value present at the sampling edge is captured.
- The scan state machine has two states, MANUAL and SCAN. The state register follows mode on enabled edges. The SCAN state includes the dwell and channel counters described above.
- The rst_n deassertion edge is treated as synchronous by the design. External reset synchronisation is not this block's responsibility.

## Configuration
- MUXN_SCAN_PARITY_EN defined:
  - Port y_par exists and is registered alongside y, equal to ^y of the loaded value.
  - Resets to 0 and holds when en=0.
  - Out-of-range selects give y_par = 0.
- MUXN_SCAN_PARITY_EN undefined: the y_par port and its register are absent. All other behaviour is identical.

## Structure
- Package muxn_pkg contains:
  - The mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - A state typedef (MANUAL, SCAN).
  - The max(1, clog2) select-width function.
- Sub-module muxn_scan_ctr holds the dwell counter and the channel counter with wrap. Its ports are clk, rst_n, en, clr, and ch out.
- The top level contains only the select mux, the range check and the output registers.

## Test plan
All scenarios use N_CH=4, DW=8 unless stated.
- Reset: assert rst_n=0 mid-cycle → y=0, y_ch=0, y_vld=0 immediately, without waiting for a clock edge.
- Manual mode: d={8'h44,8'h33,8'h22,8'h11}, s=2, en=1 → y=8'h33, y_ch=2, y_vld=1 one edge later. Sweep s=0..3 and compare against a reference model.
- Auto-scan: mode=1, SCAN_DIV=3 → y_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 over 13 enabled edges, with y tracking the matching d slice.
- Enable gating in auto mode: drop en for 5 cycles at y_ch=1 with dwell=1 → all outputs hold. After en returns, channel 1 completes its remaining 2 cycles (SCAN_DIV=3 → dwell 1→2, then advance).
- Out-of-range select: N_CH=3, manual s=3 → y=0, y_ch=3, y_vld=0.
- Mode switch and parity: auto→manual→auto restarts the scan at channel 0. With MUXN_SCAN_PARITY_EN, y=8'h07 → y_par=1 and y=8'h03 → y_par=0.
